// File: rtl/auto_gain_control.sv
// ---------------------------------------------------------------------------
// auto_gain_control
//
// Purpose:
//   Selects one of four gain relays so that an ADC signal sits in range.
//   Every ADC sample is checked for overload (immediate step-down), and the
//   peak of each fixed-length window of samples decides whether the gain can
//   step up or whether the loop is locked ("stable").
//
// Ports:
//   clk         in   1   system clock, every flop uses its rising edge
//   rst_n       in   1   asynchronous, active-low reset
//   adc_clk     in   1   ADC sample strobe, synchronized and used as data
//   adc_data    in   12  unsigned ADC code, captured on the adc_clk rise
//   relay_ctrl  out  2   gain relay select (current gain index, 3 = highest)
//   stable      out  1   high once a full window has been measured in range
//
// Configuration macro:
//   AGC_SETTLE_EN  defined   -> SETTLE_LEN samples are discarded after every
//                               relay change before measuring resumes.
//                  undefined -> no settling samples; measuring resumes on the
//                               very next sample after a relay change.
// ---------------------------------------------------------------------------
module auto_gain_control #(
   parameter int unsigned      OVER_TH    = 3800,
   parameter int unsigned      UP_TH      = 1800,
   parameter int unsigned      WIN_LEN    = 256,
   parameter int unsigned      SETTLE_LEN = 16,
   parameter logic [3:0][7:0]  GAIN_MAP   = {8'd8, 8'd4, 8'd2, 8'd1}
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        adc_clk,
   input  logic [11:0] adc_data,
   output logic [1:0]  relay_ctrl,
   output logic        stable
);

   localparam logic [1:0] SETTLE  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam logic [11:0] OVER_TH_C    = 12'(OVER_TH);
   localparam logic [11:0] UP_TH_C      = 12'(UP_TH);
   localparam logic [8:0]  WIN_LEN_C    = 9'(WIN_LEN);
   localparam logic [8:0]  SETTLE_LEN_C = 9'(SETTLE_LEN);
   localparam logic [1:0]  IDX_MAX      = 2'd3;

   // Elaboration-time sanity checks: the window and settle counts must fit
   // the 9-bit counter, and the relay order must be ascending in gain since
   // stepping the index up is assumed to raise the gain.
   if (WIN_LEN < 1 || WIN_LEN > 511) begin : g_badWinLen
      $error("auto_gain_control: WIN_LEN must be 1..511");
   end
   if (SETTLE_LEN > 511) begin : g_badSettleLen
      $error("auto_gain_control: SETTLE_LEN must be 0..511");
   end
   if (!(GAIN_MAP[0] < GAIN_MAP[1] && GAIN_MAP[1] < GAIN_MAP[2] &&
         GAIN_MAP[2] < GAIN_MAP[3])) begin : g_badGainMap
      $error("auto_gain_control: GAIN_MAP must be strictly ascending");
   end

   logic        adcSync1_q, adcSync2_q, adcPrev_q;
   logic        adcRise;
   logic [11:0] sample_q;
   logic        sampleValid_q;

   logic [1:0]  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        stable_q, stable_d;
   logic [11:0] peak_q, peak_d;
   logic [8:0]  count_q, count_d;

   logic        overload;
   logic        settleActive;
   logic        settleDone;
   logic [8:0]  countInc;
   logic [11:0] peakNew;

   // Two-flop synchronizer for the ADC strobe plus a delayed copy for rising
   // edge detection. On the detected edge the data bus has been stable for
   // at least half an adc_clk period, so it is safe to capture it here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adcSync1_q    <= 1'b0;
         adcSync2_q    <= 1'b0;
         adcPrev_q     <= 1'b0;
         sample_q      <= '0;
         sampleValid_q <= 1'b0;
      end else begin
         adcSync1_q    <= adc_clk;
         adcSync2_q    <= adcSync1_q;
         adcPrev_q     <= adcSync2_q;
         sampleValid_q <= adcRise;
         if (adcRise) begin
            sample_q <= adc_data;
         end
      end
   end

   assign adcRise = adcSync2_q & ~adcPrev_q;

   // The counter is shared: in SETTLE it counts discarded samples, in
   // MEASURE/LOCKED it counts window samples. It is always cleared on a
   // state change so the two uses never mix.
   assign overload   = (sample_q >= OVER_TH_C);
   assign countInc   = count_q + 9'd1;
   assign peakNew    = (sample_q > peak_q) ? sample_q : peak_q;
   assign settleDone = (countInc >= SETTLE_LEN_C);

`ifdef AGC_SETTLE_EN
   assign settleActive = (state_q == SETTLE);
`else
   // Without settling, a sample arriving in SETTLE is treated as the first
   // sample of a fresh measurement window.
   assign settleActive = 1'b0;
`endif

   // Gain decision logic, evaluated once per captured sample. Overload is
   // checked first so that it wins over settling and over a window end that
   // falls on the same sample.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      stable_d = stable_q;
      peak_d   = peak_q;
      count_d  = count_q;
      if (sampleValid_q) begin
         if (overload) begin
            if (idx_q != 2'd0) begin
               idx_d = idx_q - 2'd1;
            end
            stable_d = 1'b0;
            state_d  = SETTLE;
            peak_d   = '0;
            count_d  = '0;
         end else if (settleActive) begin
            if (settleDone) begin
               state_d = MEASURE;
               peak_d  = '0;
               count_d = '0;
            end else begin
               count_d = countInc;
            end
         end else if (countInc == WIN_LEN_C) begin
            if (peakNew < UP_TH_C && idx_q != IDX_MAX) begin
               idx_d    = idx_q + 2'd1;
               stable_d = 1'b0;
               state_d  = SETTLE;
            end else begin
               stable_d = 1'b1;
               state_d  = LOCKED;
            end
            peak_d  = '0;
            count_d = '0;
         end else begin
            peak_d  = peakNew;
            count_d = countInc;
            if (state_q == SETTLE) begin
               state_d = MEASURE;
            end
         end
      end
   end

   // Control state registers; reset selects the highest gain and restarts
   // from SETTLE so any partial measurement is thrown away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SETTLE;
         idx_q    <= IDX_MAX;
         stable_q <= 1'b0;
         peak_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         stable_q <= stable_d;
         peak_q   <= peak_d;
         count_q  <= count_d;
      end
   end

   assign relay_ctrl = idx_q;
   assign stable     = stable_q;

endmodule

// File: tb/tb_auto_gain_control.sv
// ---------------------------------------------------------------------------
// tb_auto_gain_control
//
// Directed bench for auto_gain_control with default parameters. Samples are
// delivered as slow adc_clk pulses (data changes with the falling strobe).
// The settling length depends on AGC_SETTLE_EN, mirrored here by SETTLE_N.
// ---------------------------------------------------------------------------
module tb_auto_gain_control;

`ifdef AGC_SETTLE_EN
   localparam int SETTLE_N = 16;
`else
   localparam int SETTLE_N = 0;
`endif
   localparam int WIN = 256;

   logic        clk;
   logic        rst_n;
   logic        adc_clk;
   logic [11:0] adc_data;
   logic [1:0]  relay_ctrl;
   logic        stable;

   int nCompared;
   int nMismatched;

   auto_gain_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .adc_clk    (adc_clk),
      .adc_data   (adc_data),
      .relay_ctrl (relay_ctrl),
      .stable     (stable)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One ADC sample per call: data changes with the falling strobe, then the
   // strobe rises and stays high long enough for the decision to land.
   task automatic applyStimulus(input logic [11:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         adc_clk  = 1'b0;
         adc_data = data;
         repeat (4) @(negedge clk);
         adc_clk = 1'b1;
         repeat (5) @(negedge clk);
      end
   endtask

   // Reset holds highest gain and unstable, both during and after reset
   task automatic test_reset();
      rst_n    = 1'b0;
      adc_clk  = 1'b0;
      adc_data = 12'd0;
      repeat (3) @(negedge clk);
      nCompared++;
      if (relay_ctrl !== 2'b11) begin
         nMismatched++;
         $display("[TB] FAIL reset_relay got=%b want=%b", relay_ctrl, 2'b11);
      end
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_stable got=%b want=%b", stable, 1'b0);
      end
      rst_n = 1'b1;
      #100;
      @(negedge clk);
      nCompared++;
      if (relay_ctrl !== 2'b11) begin
         nMismatched++;
         $display("[TB] FAIL post_reset_relay got=%b want=%b", relay_ctrl, 2'b11);
      end
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL post_reset_stable got=%b want=%b", stable, 1'b0);
      end
   endtask

   // Overload must step down within 4 clk of the strobe rise; each further
   // overload sample steps down once more
   task automatic test_overload();
      adc_clk  = 1'b0;
      adc_data = 12'd3890;
      repeat (4) @(negedge clk);
      adc_clk = 1'b1;
      repeat (4) @(negedge clk);
      nCompared++;
      if (relay_ctrl !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL overload_latency relay got=%b want=%b", relay_ctrl, 2'b10);
      end
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL overload_stable got=%b want=%b", stable, 1'b0);
      end
      @(negedge clk);
      applyStimulus(12'd3890, 1);
      nCompared++;
      if (relay_ctrl !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL overload_second relay got=%b want=%b", relay_ctrl, 2'b01);
      end
   endtask

   // Low window peak steps up exactly on the last sample of the window
   task automatic test_step_up();
      applyStimulus(12'd819, SETTLE_N + WIN - 1);
      nCompared++;
      if (relay_ctrl !== 2'b01) begin
         nMismatched++;
         $display("[TB] FAIL step_up_early relay got=%b want=%b", relay_ctrl, 2'b01);
      end
      applyStimulus(12'd819, 1);
      nCompared++;
      if (relay_ctrl !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL step_up_window_end relay got=%b want=%b", relay_ctrl, 2'b10);
      end
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL step_up_stable got=%b want=%b", stable, 1'b0);
      end
   endtask

   // At idx 2 a weak source steps up to idx 3, then the doubled level locks
   task automatic test_settle_lock();
      applyStimulus(12'd1638, SETTLE_N + WIN);
      nCompared++;
      if (relay_ctrl !== 2'b11) begin
         nMismatched++;
         $display("[TB] FAIL lock_step_up relay got=%b want=%b", relay_ctrl, 2'b11);
      end
      applyStimulus(12'd3276, SETTLE_N + WIN - 1);
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL lock_early stable got=%b want=%b", stable, 1'b0);
      end
      applyStimulus(12'd3276, 1);
      nCompared++;
      if (stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL lock_rise stable got=%b want=%b", stable, 1'b1);
      end
      nCompared++;
      if (relay_ctrl !== 2'b11) begin
         nMismatched++;
         $display("[TB] FAIL lock_relay got=%b want=%b", relay_ctrl, 2'b11);
      end
   endtask

   // Overload while locked drops stable and gain; in-range data relocks
   task automatic test_locked_overload();
      applyStimulus(12'd3890, 1);
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL locked_ovl_stable got=%b want=%b", stable, 1'b0);
      end
      nCompared++;
      if (relay_ctrl !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL locked_ovl_relay got=%b want=%b", relay_ctrl, 2'b10);
      end
      applyStimulus(12'd2000, SETTLE_N + WIN);
      nCompared++;
      if (stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL relock_stable got=%b want=%b", stable, 1'b1);
      end
      applyStimulus(12'd2000, 512 - SETTLE_N - WIN);
      nCompared++;
      if (relay_ctrl !== 2'b10 || stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL relock_hold relay/stable got=%b/%b want=10/1", relay_ctrl, stable);
      end
   endtask

   // One code below the overload threshold is harmless, the threshold trips
   task automatic test_over_threshold();
      applyStimulus(12'd3799, 1);
      nCompared++;
      if (relay_ctrl !== 2'b10 || stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL below_over_th relay/stable got=%b/%b want=10/1", relay_ctrl, stable);
      end
      applyStimulus(12'd3800, 1);
      nCompared++;
      if (relay_ctrl !== 2'b01 || stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL at_over_th relay/stable got=%b/%b want=01/0", relay_ctrl, stable);
      end
   endtask

   // Repeated overloads saturate at idx 0
   task automatic test_no_wrap();
      applyStimulus(12'd4095, 10);
      nCompared++;
      if (relay_ctrl !== 2'b00) begin
         nMismatched++;
         $display("[TB] FAIL no_wrap_low relay got=%b want=%b", relay_ctrl, 2'b00);
      end
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL no_wrap_stable got=%b want=%b", stable, 1'b0);
      end
   endtask

   // A peak equal to UP_TH locks; one code lower requests a step-up
   task automatic test_up_threshold();
      applyStimulus(12'd1800, SETTLE_N + WIN);
      nCompared++;
      if (relay_ctrl !== 2'b00 || stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL at_up_th relay/stable got=%b/%b want=00/1", relay_ctrl, stable);
      end
      applyStimulus(12'd1799, WIN);
      nCompared++;
      if (relay_ctrl !== 2'b01 || stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL below_up_th relay/stable got=%b/%b want=01/0", relay_ctrl, stable);
      end
   endtask

   // Weak signal climbs to idx 3 and stays there, locking after a window
   task automatic test_top_saturate();
      applyStimulus(12'd100, 2 * (SETTLE_N + WIN));
      nCompared++;
      if (relay_ctrl !== 2'b11 || stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL climb_top relay/stable got=%b/%b want=11/0", relay_ctrl, stable);
      end
      applyStimulus(12'd100, SETTLE_N + WIN);
      nCompared++;
      if (relay_ctrl !== 2'b11 || stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL top_first_window relay/stable got=%b/%b want=11/1", relay_ctrl, stable);
      end
      applyStimulus(12'd100, 600 - SETTLE_N - WIN);
      nCompared++;
      if (relay_ctrl !== 2'b11 || stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL top_hold relay/stable got=%b/%b want=11/1", relay_ctrl, stable);
      end
   endtask

   // Reset mid-window acts immediately and discards the partial window
   task automatic test_reset_mid_window();
      applyStimulus(12'd3890, 1);
      applyStimulus(12'd2000, 50);
      nCompared++;
      if (relay_ctrl !== 2'b10) begin
         nMismatched++;
         $display("[TB] FAIL pre_reset relay got=%b want=%b", relay_ctrl, 2'b10);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nCompared++;
      if (relay_ctrl !== 2'b11 || stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL async_reset relay/stable got=%b/%b want=11/0", relay_ctrl, stable);
      end
      adc_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(12'd2000, SETTLE_N + WIN - 1);
      nCompared++;
      if (stable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL partial_discard stable got=%b want=%b", stable, 1'b0);
      end
      applyStimulus(12'd2000, 1);
      nCompared++;
      if (relay_ctrl !== 2'b11 || stable !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL after_reset_lock relay/stable got=%b/%b want=11/1", relay_ctrl, stable);
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_overload();
      test_step_up();
      test_settle_lock();
      test_locked_overload();
      test_over_threshold();
      test_no_wrap();
      test_up_threshold();
      test_top_saturate();
      test_reset_mid_window();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/auto_gain_control.md
AUTO_GAIN_CONTROL -- requirements
Module: auto_gain_control

Interface
REQ-001 Parameter OVER_TH, default 3800, meaning: overload code (about 1856 mV at 2 V / 4095 full scale); any sample >= OVER_TH forces an immediate gain step-down.
REQ-002 Parameter UP_TH, default 1800, meaning: window peak below this code requests a gain step-up.
REQ-003 Parameter WIN_LEN, default 256, meaning: number of ADC samples per measurement window.
REQ-004 Parameter SETTLE_LEN, default 16, meaning: number of samples discarded after every relay change.
REQ-005 Parameter GAIN_MAP, default {1,2,4,8} indexed 0..3, meaning: nominal gain per index; the module itself does not use it arithmetically.
REQ-006 clk  input  1  system clock; the only clock; all flops on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 adc_clk  input  1  ADC sample strobe; treated as data, never as a clock.
REQ-009 adc_data  input  12  unsigned ADC code (0..4095); changes on the adc_clk falling edge.
REQ-010 relay_ctrl  output  2  gain relay select; always equals the internal register current_gain_idx.
REQ-011 stable  output  1  high when the gain has settled in range.

Function
REQ-012 adc_clk SHALL pass a 2-flop synchronizer plus rising-edge detect; adc_data SHALL be registered on the detected edge, forming one "sample".
REQ-013 The FSM SHALL have three states: SETTLE, MEASURE, LOCKED.
- SETTLE: discard SETTLE_LEN samples, then enter MEASURE with peak and count cleared.
REQ-014 MEASURE and LOCKED SHALL track peak = max(sample) and count samples up to WIN_LEN.
REQ-015 Overload SHALL take priority in every state, including SETTLE. A sample >= OVER_TH SHALL:
- decrement current_gain_idx if it is > 0 (saturate at 0);
- clear stable;
- enter SETTLE;
- all within 4 clk of the synchronized adc_clk rising edge.
REQ-016 At the end of a window (count == WIN_LEN):
- peak < UP_TH and idx < 3: increment idx, clear stable, enter SETTLE;
- otherwise: set stable, enter or stay in LOCKED, and restart the window.
REQ-017 In LOCKED, stable SHALL stay high until an overload or step-up decision occurs.
REQ-018 Only one gain step per decision; idx SHALL never wrap (no change above 3 or below 0).
REQ-019 An overload and a window end in the same sample SHALL resolve as overload.
REQ-020 Peak and counter SHALL be 12-bit and 9-bit respectively; the compare uses unsigned arithmetic.

Reset
REQ-021 While rst_n = 0, with immediate effect:
- current_gain_idx = 3, so relay_ctrl = 2'b11 (highest gain);
- stable = 0;
- state = SETTLE;
- counters, peak and synchronizer flops = 0.
REQ-022 A reset asserted mid-window SHALL discard all partial measurement; operation resumes from SETTLE on the first sample after release.

Configuration
REQ-023 Macro AGC_SETTLE_EN:
- defined: the SETTLE state discards SETTLE_LEN samples as specified.
- undefined: SETTLE lasts zero samples, so MEASURE starts on the next sample after any relay change; overload priority is unchanged.

Verification
REQ-024 Reset release, then 100 ns with adc_data = 0 -> relay_ctrl = 11, stable = 0.
REQ-025 After reset, 2 samples of 3890 (1900 mV) -> relay_ctrl = 10 within 4 clk of the first sample's adc_clk rise; stable = 0.
REQ-026 At idx 2, 512 samples of 1638 (800 mV), source gain doubling per step -> one step-up to idx 3; stable rises after SETTLE_LEN + WIN_LEN samples at the in-range level (3276 < OVER_TH).
REQ-027 Locked at idx 3, one sample of 3890 -> stable falls, relay_ctrl = 10; then 512 in-range samples of 2000 -> stable rises again, idx stays 2.
REQ-028 At idx 0, 10 samples of 4095 -> idx stays 0 (no wrap), stable = 0; at idx 3, 600 samples of 100 -> idx stays 3, stable = 1 after the first full window.
